// File: rtl/uart_frame_scheduler_pkg.sv
// Shared types and ASCII helpers for the UART frame scheduler.
// Imported by uart_frame_scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        HOLDOFF
    } sched_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BAD  = 8'h3F;

    // Returns {ascii_byte, bad}; non-BCD nibbles map to '?'.
    function automatic logic [8:0] bcd_to_ascii(input logic [3:0] nibble);
        if (nibble > 4'd9) begin
            return {ASCII_BAD, 1'b1};
        end
        return {ASCII_ZERO + {4'h0, nibble}, 1'b0};
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_arbiter.sv
// Two-way round-robin arbiter; remembers the last winner and favours the other
// requester when both ask at once.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 means requester 1 won last, so requester 0 has priority
    logic last_one;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_one ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_one <= 1'b1;
        end else if (advance) begin
            last_one <= grant[1];
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Arbitrates two BCD time sources onto one byte UART transmitter, sending
// "HH:MM" (plus optional CR LF) per grant, followed by a rate-limiting holdoff.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 50000000,
    parameter bit          SEND_CRLF      = 1'b1,
    parameter logic [7:0]  SEP_CHAR       = 8'h3A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] digits0,
    input  logic [15:0] digits1,
    output logic [1:0]  ack,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        frame_done,
    output logic        bad_digit
);

    localparam int unsigned HOLD_W   = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [2:0]  LAST_IDX = SEND_CRLF ? 3'd6 : 3'd4;

    sched_state_t      state;
    logic [2:0]        idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       payload;
    logic              bad;

    logic [1:0]  arb_grant;
    logic        arb_advance;
    logic [15:0] grant_digits;
    logic [8:0]  next_byte;

    function automatic logic [8:0] frame_byte(input logic [2:0] i, input logic [15:0] p);
        logic [8:0] r;
        r = '0;
        case (i)
            3'd0:    r = bcd_to_ascii(p[15:12]);
            3'd1:    r = bcd_to_ascii(p[11:8]);
            3'd2:    r = {SEP_CHAR, 1'b0};
            3'd3:    r = bcd_to_ascii(p[7:4]);
            3'd4:    r = bcd_to_ascii(p[3:0]);
            3'd5:    r = {ASCII_CR, 1'b0};
            3'd6:    r = {ASCII_LF, 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

    // Byte launched on the next edge: byte 0 of the incoming payload at grant,
    // otherwise the following byte of the latched payload.
    always_comb begin
        arb_advance  = (state == IDLE) && (req != 2'b00);
        grant_digits = arb_grant[1] ? digits1 : digits0;
        if (state == IDLE) begin
            next_byte = frame_byte(3'd0, grant_digits);
        end else begin
            next_byte = frame_byte(idx + 3'd1, payload);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            payload    <= '0;
            bad        <= 1'b0;
            ack        <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bad_digit  <= 1'b0;
        end else begin
            ack        <= '0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            bad_digit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        payload  <= grant_digits;
                        idx      <= '0;
                        bad      <= next_byte[0];
                        tx_data  <= next_byte[8:1];
                        tx_start <= 1'b1;
                        ack      <= arb_grant;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            hold_cnt   <= HOLD_W'(HOLDOFF_CYCLES - 1);
                            frame_done <= 1'b1;
                            bad_digit  <= bad;
                            state      <= HOLDOFF;
                        end else begin
                            idx      <= idx + 3'd1;
                            bad      <= bad | next_byte[0];
                            tx_data  <= next_byte[8:1];
                            tx_start <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
